ibex_lsm_sched: RTL and testbench

Controller and arbiter for the single shared load/store-mask (LSM) generator in the Ibex core. It arbitrates mask requests from two requesters: the LSU data port and an auxiliary port used by the RF/memory scrubber. It drives the generator's address and seed inputs, registers the generated 32-bit mask back to the winning requester, and owns the 32-bit seed register. It updates the seed on CSR writes and on a periodic self-refresh that runs the generator on a fixed address.

---
 rtl/ibex_lsm_sched_if.sv | 33 +++
 rtl/ibex_lsm_sched.sv | 101 ++++++++++
 tb/tb_ibex_lsm_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ibex_lsm_sched_if.sv
// Request, response, CSR and generator signals of the LSM scheduler.
// The scheduler uses the slave modport and the surrounding logic uses the master modport.
interface ibex_lsm_sched_if;
   logic        lsu_req_i;
   logic [31:0] lsu_addr_i;
   logic        lsu_gnt_o;
   logic        lsu_rvalid_o;
   logic        aux_req_i;
   logic [31:0] aux_addr_i;
   logic        aux_gnt_o;
   logic        aux_rvalid_o;
   logic [31:0] mask_o;
   logic        seed_we_i;
   logic [31:0] seed_wdata_i;
   logic        seed_busy_o;
   logic [31:0] gen_addr_o;
   logic [31:0] gen_seed_o;
   logic [31:0] gen_mask_i;

   modport slave (
      input  lsu_req_i, lsu_addr_i, aux_req_i, aux_addr_i,
      input  seed_we_i, seed_wdata_i, gen_mask_i,
      output lsu_gnt_o, lsu_rvalid_o, aux_gnt_o, aux_rvalid_o,
      output mask_o, seed_busy_o, gen_addr_o, gen_seed_o
   );

   modport master (
      output lsu_req_i, lsu_addr_i, aux_req_i, aux_addr_i,
      output seed_we_i, seed_wdata_i, gen_mask_i,
      input  lsu_gnt_o, lsu_rvalid_o, aux_gnt_o, aux_rvalid_o,
      input  mask_o, seed_busy_o, gen_addr_o, gen_seed_o
   );
endinterface

// File: rtl/ibex_lsm_sched.sv
// Arbiter and seed controller for the shared load/store-mask generator:
// round-robin LSU/AUX grants, CSR seed writes and periodic self-refresh.
module ibex_lsm_sched #(
   parameter logic [31:0] SeedResetVal  = 32'h0000_0001,
   parameter int unsigned RefreshPeriod = 256,
   parameter logic [31:0] RefreshAddr   = 32'hFFFF_FFFC
) (
   input  logic            clk_i,
   input  logic            rst_i,
   ibex_lsm_sched_if.slave bus
);
   localparam logic [15:0] LP_PERIOD = 16'(RefreshPeriod);

   typedef enum logic [1:0] {ST_IDLE, ST_RESEED, ST_REFRESH} state_e;

   state_e      r_state;
   state_e      w_state_next;
   logic [31:0] r_seed;
   logic [31:0] r_mask;
   logic        r_lsu_rvalid;
   logic        r_aux_rvalid;
   logic        r_prio_aux;
   logic [15:0] r_cnt;

   logic        w_cnt_full;
   logic        w_can_grant;
   logic        w_lsu_gnt;
   logic        w_aux_gnt;
   logic [31:0] w_gen_addr;

   assign w_cnt_full = (r_cnt == LP_PERIOD);

   always_comb begin
      w_state_next = r_state;
      w_can_grant  = 1'b0;
      w_lsu_gnt    = 1'b0;
      w_aux_gnt    = 1'b0;
      w_gen_addr   = 32'h0;

      // A CSR write pre-empts everything, including an in-flight refresh.
      if (bus.seed_we_i) begin
         w_state_next = ST_RESEED;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cnt_full) w_state_next = ST_REFRESH;
               else            w_can_grant  = 1'b1;
            end
            ST_RESEED:  w_state_next = ST_IDLE;
            ST_REFRESH: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
         endcase
      end

      // r_prio_aux breaks ties only; a lone requester always wins.
      w_lsu_gnt = w_can_grant && bus.lsu_req_i && (!bus.aux_req_i || !r_prio_aux);
      w_aux_gnt = w_can_grant && bus.aux_req_i && (!bus.lsu_req_i ||  r_prio_aux);

      if (r_state == ST_REFRESH) w_gen_addr = RefreshAddr;
      else if (w_lsu_gnt)        w_gen_addr = bus.lsu_addr_i;
      else if (w_aux_gnt)        w_gen_addr = bus.aux_addr_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_seed       <= SeedResetVal;
         r_mask       <= 32'h0;
         r_lsu_rvalid <= 1'b0;
         r_aux_rvalid <= 1'b0;
         r_prio_aux   <= 1'b0;
         r_cnt        <= 16'h0;
      end else begin
         r_state      <= w_state_next;
         r_lsu_rvalid <= w_lsu_gnt;
         r_aux_rvalid <= w_aux_gnt;

         if (w_lsu_gnt || w_aux_gnt) begin
            r_mask     <= bus.gen_mask_i;
            r_prio_aux <= w_lsu_gnt;
         end

         if (bus.seed_we_i)               r_seed <= bus.seed_wdata_i;
         else if (r_state == ST_REFRESH)  r_seed <= bus.gen_mask_i;

         if (bus.seed_we_i || r_state == ST_REFRESH)
            r_cnt <= 16'h0;
         else if ((w_lsu_gnt || w_aux_gnt) && !w_cnt_full)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   assign bus.lsu_gnt_o    = w_lsu_gnt;
   assign bus.aux_gnt_o    = w_aux_gnt;
   assign bus.lsu_rvalid_o = r_lsu_rvalid;
   assign bus.aux_rvalid_o = r_aux_rvalid;
   assign bus.mask_o       = r_mask;
   assign bus.seed_busy_o  = (r_state != ST_IDLE) || bus.seed_we_i;
   assign bus.gen_addr_o   = w_gen_addr;
   assign bus.gen_seed_o   = r_seed;
endmodule

// File: tb/tb_ibex_lsm_sched.sv
// Scoreboard bench for ibex_lsm_sched: directed grants push expected masks,
// a negedge monitor pops and compares them whenever an rvalid appears.
module tb_ibex_lsm_sched;
   localparam logic [31:0] SEED_RST = 32'h0000_0001;
   localparam logic [31:0] REF_ADDR = 32'hFFFF_FFFC;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [31:0] exp_seed;
   logic [32:0] exp_q[$];   // {port (1 = AUX), mask}

   ibex_lsm_sched_if bus ();

   ibex_lsm_sched #(
      .SeedResetVal (SEED_RST),
      .RefreshPeriod(4),
      .RefreshAddr  (REF_ADDR)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   function automatic logic [31:0] gen_f(input logic [31:0] s, input logic [31:0] a);
      logic [31:0] t;
      t = s ^ {a[15:0], a[31:16]};
      return (t * 32'h9E37_79B9) ^ (a + 32'h0000_0055);
   endfunction

   assign bus.gen_mask_i = gen_f(bus.gen_seed_o, bus.gen_addr_o);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: every rvalid pulse must match the oldest expected mask.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst && (bus.lsu_rvalid_o || bus.aux_rvalid_o)) begin
            chk("rvalid_exclusive", 32'(bus.lsu_rvalid_o & bus.aux_rvalid_o), 32'h0);
            if (exp_q.size() == 0) begin
               chk("unexpected_rvalid", 32'h1, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("rvalid_port", 32'(bus.aux_rvalid_o), 32'(e[32]));
               chk("mask", bus.mask_o, e[31:0]);
               $display("rvalid port=%s mask=%h", bus.aux_rvalid_o ? "AUX" : "LSU", bus.mask_o);
            end
         end
      end
   end

   // One cycle of stimulus, entered and left at posedge+1.
   task automatic step(input logic lr, input logic [31:0] la,
                       input logic ar, input logic [31:0] aa,
                       input logic we, input logic [31:0] wd,
                       input logic elg, input logic eag,
                       input logic ebusy, input logic eref);
      bus.lsu_req_i    = lr;
      bus.lsu_addr_i   = la;
      bus.aux_req_i    = ar;
      bus.aux_addr_i   = aa;
      bus.seed_we_i    = we;
      bus.seed_wdata_i = wd;
      @(negedge clk);
      chk("lsu_gnt", 32'(bus.lsu_gnt_o), 32'(elg));
      chk("aux_gnt", 32'(bus.aux_gnt_o), 32'(eag));
      chk("seed_busy", 32'(bus.seed_busy_o), 32'(ebusy));
      chk("gen_seed", bus.gen_seed_o, exp_seed);
      if (elg) begin
         chk("gen_addr_lsu", bus.gen_addr_o, la);
         exp_q.push_back({1'b0, gen_f(exp_seed, la)});
      end
      if (eag) begin
         chk("gen_addr_aux", bus.gen_addr_o, aa);
         exp_q.push_back({1'b1, gen_f(exp_seed, aa)});
      end
      if (eref) chk("gen_addr_refresh", bus.gen_addr_o, REF_ADDR);
      $display("step lreq=%b areq=%b we=%b lgnt=%b agnt=%b busy=%b",
               lr, ar, we, bus.lsu_gnt_o, bus.aux_gnt_o, bus.seed_busy_o);
      if (we)        exp_seed = wd;
      else if (eref) exp_seed = gen_f(exp_seed, REF_ADDR);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_seed = SEED_RST;
      rst = 1'b1;
      bus.lsu_req_i = 1'b0; bus.lsu_addr_i = 32'h0;
      bus.aux_req_i = 1'b0; bus.aux_addr_i = 32'h0;
      bus.seed_we_i = 1'b0; bus.seed_wdata_i = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_mask", bus.mask_o, 32'h0);
      chk("rst_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
      chk("rst_aux_rvalid", 32'(bus.aux_rvalid_o), 32'h0);
      chk("rst_seed", bus.gen_seed_o, SEED_RST);
      chk("rst_busy", 32'(bus.seed_busy_o), 32'h0);
      chk("rst_gen_addr", bus.gen_addr_o, 32'h0);
      @(posedge clk);
      #1;

      //   lr  la            ar  aa            we  wd            lg  ag  busy ref
      step(1, 32'h0000_1000, 0, 32'h0,         0, 32'h0,         1,  0,  0,   0);
      step(0, 32'h0,         1, 32'h0000_2000, 0, 32'h0,         0,  1,  0,   0);
      // Both requesting: alternate, with a refresh after the 4th issued mask.
      step(1, 32'h0000_3000, 1, 32'h0000_4000, 0, 32'h0,         1,  0,  0,   0);
      step(1, 32'h0000_3004, 1, 32'h0000_4000, 0, 32'h0,         0,  1,  0,   0);
      step(1, 32'h0000_3004, 1, 32'h0000_4004, 0, 32'h0,         0,  0,  0,   0);
      step(1, 32'h0000_3004, 1, 32'h0000_4004, 0, 32'h0,         0,  0,  1,   1);
      step(1, 32'h0000_3004, 1, 32'h0000_4004, 0, 32'h0,         1,  0,  0,   0);
      step(1, 32'h0000_3008, 1, 32'h0000_4004, 0, 32'h0,         0,  1,  0,   0);
      step(0, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0,  0,   0);
      // CSR write with LSU waiting: write cycle and RESEED stall.
      step(1, 32'h0000_5000, 0, 32'h0,         1, 32'hDEAD_BEEF, 0,  0,  1,   0);
      step(1, 32'h0000_5000, 0, 32'h0,         0, 32'h0,         0,  0,  1,   0);
      step(1, 32'h0000_5000, 0, 32'h0,         0, 32'h0,         1,  0,  0,   0);
      step(1, 32'h0000_6000, 0, 32'h0,         0, 32'h0,         1,  0,  0,   0);
      step(1, 32'h0000_6004, 0, 32'h0,         0, 32'h0,         1,  0,  0,   0);
      step(0, 32'h0,         1, 32'h0000_7000, 0, 32'h0,         0,  1,  0,   0);
      // Refresh entered, then overridden by a CSR write in the REFRESH cycle.
      step(0, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0,  0,   0);
      step(0, 32'h0,         0, 32'h0,         1, 32'h1234_5678, 0,  0,  1,   1);
      step(1, 32'h0000_8000, 0, 32'h0,         0, 32'h0,         0,  0,  1,   0);
      step(1, 32'h0000_8000, 0, 32'h0,         0, 32'h0,         1,  0,  0,   0);
      step(1, 32'h0000_9000, 0, 32'h0,         0, 32'h0,         1,  0,  0,   0);

      // Reset in the cycle after a grant: the pending rvalid must vanish.
      bus.lsu_req_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drop_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
      chk("rst_mid_seed", bus.gen_seed_o, SEED_RST);
      chk("rst_mid_mask", bus.mask_o, 32'h0);
      exp_q.delete();
      exp_seed = SEED_RST;
      @(posedge clk);
      #1 rst = 1'b0;

      step(1, 32'h0000_A000, 1, 32'h0000_B000, 0, 32'h0,         1,  0,  0,   0);
      step(1, 32'h0000_A004, 1, 32'h0000_B000, 0, 32'h0,         0,  1,  0,   0);
      step(0, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0,  0,   0);
      step(0, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0,  0,   0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
